// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
package dmem_arb_pkg;

   // Which port won the most recent granted beat; NONE after an idle cycle.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_P0   = 2'd1,
      OWN_P1   = 2'd2
   } owner_t;

   localparam int MAX_BURST_DEF = 4;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   // Translate a winning port index into the matching owner encoding.
   function automatic owner_t portToOwner(input logic port);
      return (port == PORT1) ? OWN_P1 : OWN_P0;
   endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection between the two requesters.
module dmem_arb_pick
   import dmem_arb_pkg::*;
#(
   parameter int MAX_BURST = MAX_BURST_DEF,
   parameter int CW        = $clog2(MAX_BURST + 1)
) (
   input  logic [1:0]    reqs_i,
   input  owner_t        owner_i,
   input  logic          lock_i,
   input  logic [CW-1:0] burstCnt_i,
   input  logic          lastGnt_i,
   output logic          winner_o,
   output logic          valid_o
);

   localparam logic [CW-1:0] MaxCnt = CW'(MAX_BURST);

   logic holdOwner;

   // A locking owner keeps the bus under contention until its burst budget runs out;
   // otherwise a tie goes to the port that did not win last time.
   always_comb begin
      valid_o   = reqs_i[0] | reqs_i[1];
      winner_o  = PORT0;
      holdOwner = lock_i && (burstCnt_i < MaxCnt) && (owner_i != OWN_NONE);
      if (reqs_i == 2'b10) begin
         winner_o = PORT1;
      end else if (reqs_i == 2'b11) begin
         if (holdOwner) begin
            winner_o = (owner_i == OWN_P1) ? PORT1 : PORT0;
         end else begin
            winner_o = ~lastGnt_i;
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one async-read data memory between the core LSU (port 0) and a
// secondary requester (port 1), one word per cycle, with registered read return.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          p0_req,
   input  logic          p1_req,
   input  logic          p0_we,
   input  logic          p1_we,
   input  logic          p0_lock,
   input  logic          p1_lock,
   input  logic [AW-1:0] p0_addr,
   input  logic [AW-1:0] p1_addr,
   input  logic [DW-1:0] p0_wdata,
   input  logic [DW-1:0] p1_wdata,
   output logic          p0_gnt,
   output logic          p1_gnt,
   output logic          p0_rvalid,
   output logic          p1_rvalid,
   output logic [DW-1:0] p0_rdata,
   output logic [DW-1:0] p1_rdata,
   output logic          p0_err,
   output logic          p1_err,
   output logic          mem_read,
   output logic          mem_write,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] MaxCnt = CW'(MAX_BURST);

   owner_t        owner_q, owner_d;
   logic          lastGnt_q, lastGnt_d;
   logic          lock_q, lock_d;
   logic [CW-1:0] burstCnt_q, burstCnt_d;

   logic          p0Rvalid_q, p0Rvalid_d;
   logic          p1Rvalid_q, p1Rvalid_d;
   logic [DW-1:0] p0Rdata_q, p0Rdata_d;
   logic [DW-1:0] p1Rdata_q, p1Rdata_d;
   logic          p0Err_q, p0Err_d;
   logic          p1Err_q, p1Err_d;

   logic          winner;
   logic          pickValid;
   logic          gntValid;
   logic          selWe;
   logic          selLock;
   logic [AW-1:0] selAddr;
   logic [DW-1:0] selWdata;
   logic          aligned;

   dmem_arb_pick #(
      .MAX_BURST (MAX_BURST),
      .CW        (CW)
   ) uPick (
      .reqs_i     ({p1_req, p0_req}),
      .owner_i    (owner_q),
      .lock_i     (lock_q),
      .burstCnt_i (burstCnt_q),
      .lastGnt_i  (lastGnt_q),
      .winner_o   (winner),
      .valid_o    (pickValid)
   );

   // Route the winning port onto the memory pins; everything is quiet while in reset.
   always_comb begin
      gntValid  = pickValid & rst_n;
      selWe     = (winner == PORT1) ? p1_we    : p0_we;
      selLock   = (winner == PORT1) ? p1_lock  : p0_lock;
      selAddr   = (winner == PORT1) ? p1_addr  : p0_addr;
      selWdata  = (winner == PORT1) ? p1_wdata : p0_wdata;
      aligned   = (selAddr[1:0] == 2'b00);
      p0_gnt    = gntValid & (winner == PORT0);
      p1_gnt    = gntValid & (winner == PORT1);
      mem_write = gntValid & selWe & aligned;
      mem_read  = gntValid & ~selWe & aligned;
      mem_addr  = gntValid ? selAddr  : '0;
      mem_wdata = gntValid ? selWdata : '0;
   end

   // Ownership bookkeeping: a granted beat records its winner and lock, an idle cycle clears ownership.
   always_comb begin
      owner_d    = OWN_NONE;
      lastGnt_d  = lastGnt_q;
      lock_d     = 1'b0;
      burstCnt_d = '0;
      if (gntValid) begin
         owner_d   = portToOwner(winner);
         lastGnt_d = winner;
         lock_d    = selLock;
         if (owner_q == owner_d) begin
            burstCnt_d = (burstCnt_q == MaxCnt) ? burstCnt_q : burstCnt_q + CW'(1);
         end else begin
            burstCnt_d = CW'(1);
         end
      end
   end

   // Read return and misalignment flags for the cycle after the grant.
   always_comb begin
      p0Rvalid_d = p0_gnt & mem_read;
      p1Rvalid_d = p1_gnt & mem_read;
      p0Err_d    = p0_gnt & ~aligned;
      p1Err_d    = p1_gnt & ~aligned;
      p0Rdata_d  = p0Rvalid_d ? mem_rdata : p0Rdata_q;
      p1Rdata_d  = p1Rvalid_d ? mem_rdata : p1Rdata_q;
   end

   // All arbiter state; port 0 wins the first tie after reset because lastGnt starts at port 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q    <= OWN_NONE;
         lastGnt_q  <= PORT1;
         lock_q     <= 1'b0;
         burstCnt_q <= '0;
         p0Rvalid_q <= 1'b0;
         p1Rvalid_q <= 1'b0;
         p0Rdata_q  <= '0;
         p1Rdata_q  <= '0;
         p0Err_q    <= 1'b0;
         p1Err_q    <= 1'b0;
      end else begin
         owner_q    <= owner_d;
         lastGnt_q  <= lastGnt_d;
         lock_q     <= lock_d;
         burstCnt_q <= burstCnt_d;
         p0Rvalid_q <= p0Rvalid_d;
         p1Rvalid_q <= p1Rvalid_d;
         p0Rdata_q  <= p0Rdata_d;
         p1Rdata_q  <= p1Rdata_d;
         p0Err_q    <= p0Err_d;
         p1Err_q    <= p1Err_d;
      end
   end

   assign p0_rvalid = p0Rvalid_q;
   assign p1_rvalid = p1Rvalid_q;
   assign p0_rdata  = p0Rdata_q;
   assign p1_rdata  = p1Rdata_q;
   assign p0_err    = p0Err_q;
   assign p1_err    = p1Err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural DMem attached.
module tb_dmem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        p0_req, p1_req;
   logic        p0_we, p1_we;
   logic        p0_lock, p1_lock;
   logic [31:0] p0_addr, p1_addr;
   logic [31:0] p0_wdata, p1_wdata;
   logic        p0_gnt, p1_gnt;
   logic        p0_rvalid, p1_rvalid;
   logic [31:0] p0_rdata, p1_rdata;
   logic        p0_err, p1_err;
   logic        mem_read, mem_write;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic [31:0] memModel [16];

   int checkCount = 0;
   int passCount  = 0;

   dmem_arbiter #(
      .AW        (32),
      .DW        (32),
      .MAX_BURST (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .p0_req    (p0_req),
      .p1_req    (p1_req),
      .p0_we     (p0_we),
      .p1_we     (p1_we),
      .p0_lock   (p0_lock),
      .p1_lock   (p1_lock),
      .p0_addr   (p0_addr),
      .p1_addr   (p1_addr),
      .p0_wdata  (p0_wdata),
      .p1_wdata  (p1_wdata),
      .p0_gnt    (p0_gnt),
      .p1_gnt    (p1_gnt),
      .p0_rvalid (p0_rvalid),
      .p1_rvalid (p1_rvalid),
      .p0_rdata  (p0_rdata),
      .p1_rdata  (p1_rdata),
      .p0_err    (p0_err),
      .p1_err    (p1_err),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural DMem: async read, write on the rising edge, preset words at 0x4 and 0x8.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) memModel[i] <= 32'h0;
         memModel[1] <= 32'h1111_1111;
         memModel[2] <= 32'h2222_2222;
      end else if (mem_write) begin
         memModel[mem_addr[5:2]] <= mem_wdata;
      end
   end
   assign mem_rdata = memModel[mem_addr[5:2]];

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: observed=%h expected=%h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Drive both request ports, then let the combinational outputs settle.
   task automatic applyStimulus(input logic [1:0] req, input logic [1:0] we, input logic [1:0] lock,
                                input logic [31:0] a0, input logic [31:0] w0,
                                input logic [31:0] a1, input logic [31:0] w1);
      p0_req   = req[0];
      p1_req   = req[1];
      p0_we    = we[0];
      p1_we    = we[1];
      p0_lock  = lock[0];
      p1_lock  = lock[1];
      p0_addr  = a0;
      p0_wdata = w0;
      p1_addr  = a1;
      p1_wdata = w1;
      #1;
   endtask

   // Advance to just after the next rising edge.
   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;

      // In reset: requests present but nothing may be granted or strobed.
      applyStimulus(2'b11, 2'b01, 2'b00, 32'h0, 32'hDEAD_BEEF, 32'h8, 32'h0);
      checkOutput("rst_p0_gnt", p0_gnt, 0);
      checkOutput("rst_p1_gnt", p1_gnt, 0);
      checkOutput("rst_mem_write", mem_write, 0);
      checkOutput("rst_mem_addr", mem_addr, 0);
      stepCycle();
      checkOutput("rst_p0_rvalid", p0_rvalid, 0);
      checkOutput("rst_p0_rdata", p0_rdata, 0);
      checkOutput("rst_p1_err", p1_err, 0);
      #2 rst_n = 1'b1;
      applyStimulus(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
      stepCycle();

      // Tie after reset: P0, P1, P0, P1 with rvalid only on the owner.
      applyStimulus(2'b11, 2'b00, 2'b00, 32'h4, 32'h0, 32'h8, 32'h0);
      for (int i = 0; i < 4; i++) begin
         checkOutput("tie_p0_gnt", p0_gnt, (i % 2 == 0) ? 1 : 0);
         checkOutput("tie_p1_gnt", p1_gnt, (i % 2 == 1) ? 1 : 0);
         stepCycle();
         checkOutput("tie_p0_rvalid", p0_rvalid, (i % 2 == 0) ? 1 : 0);
         checkOutput("tie_p1_rvalid", p1_rvalid, (i % 2 == 1) ? 1 : 0);
      end
      checkOutput("tie_p0_rdata", p0_rdata, 32'h1111_1111);
      checkOutput("tie_p1_rdata", p1_rdata, 32'h2222_2222);
      applyStimulus(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
      stepCycle();

      // Single write then read back on port 0.
      applyStimulus(2'b01, 2'b01, 2'b00, 32'h0, 32'hAAAA_BBBB, 32'h0, 32'h0);
      checkOutput("wr_p0_gnt", p0_gnt, 1);
      checkOutput("wr_mem_write", mem_write, 1);
      checkOutput("wr_mem_read", mem_read, 0);
      checkOutput("wr_mem_wdata", mem_wdata, 32'hAAAA_BBBB);
      stepCycle();
      checkOutput("wr_p0_rvalid", p0_rvalid, 0);
      applyStimulus(2'b01, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
      checkOutput("rd_p0_gnt", p0_gnt, 1);
      checkOutput("rd_mem_read", mem_read, 1);
      checkOutput("rd_mem_write", mem_write, 0);
      stepCycle();
      checkOutput("rd_p0_rvalid", p0_rvalid, 1);
      checkOutput("rd_p0_rdata", p0_rdata, 32'hAAAA_BBBB);
      applyStimulus(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
      checkOutput("idle_mem_read", mem_read, 0);
      stepCycle();
      checkOutput("rd_rvalid_pulse", p0_rvalid, 0);
      checkOutput("rd_rdata_hold", p0_rdata, 32'hAAAA_BBBB);

      // Cross-port coherence: p1 writes 0x10, p0 reads it the next cycle.
      applyStimulus(2'b10, 2'b10, 2'b00, 32'h0, 32'h0, 32'h10, 32'hCCCC_DDDD);
      checkOutput("coh_p1_gnt", p1_gnt, 1);
      checkOutput("coh_mem_write", mem_write, 1);
      stepCycle();
      applyStimulus(2'b01, 2'b00, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0);
      checkOutput("coh_p0_gnt", p0_gnt, 1);
      checkOutput("coh_mem_addr", mem_addr, 32'h10);
      stepCycle();
      checkOutput("coh_p0_rvalid", p0_rvalid, 1);
      checkOutput("coh_p0_rdata", p0_rdata, 32'hCCCC_DDDD);

      // Misaligned read on port 1: consumed, no strobe, error pulse, rdata untouched.
      applyStimulus(2'b10, 2'b00, 2'b00, 32'h0, 32'h0, 32'h6, 32'h0);
      checkOutput("mis_p1_gnt", p1_gnt, 1);
      checkOutput("mis_mem_read", mem_read, 0);
      checkOutput("mis_mem_write", mem_write, 0);
      stepCycle();
      checkOutput("mis_p1_err", p1_err, 1);
      checkOutput("mis_p1_rvalid", p1_rvalid, 0);
      checkOutput("mis_p1_rdata", p1_rdata, 32'h2222_2222);
      applyStimulus(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
      stepCycle();
      checkOutput("mis_err_pulse", p1_err, 0);

      // Burst lock under contention: four p0 beats, then p1, then p0 again.
      applyStimulus(2'b11, 2'b00, 2'b01, 32'h4, 32'h0, 32'h8, 32'h0);
      for (int i = 0; i < 6; i++) begin
         checkOutput("burst_p0_gnt", p0_gnt, (i != 4) ? 1 : 0);
         checkOutput("burst_p1_gnt", p1_gnt, (i == 4) ? 1 : 0);
         stepCycle();
      end

      // Locked p0 alone runs unbounded; its budget is spent when p1 arrives.
      applyStimulus(2'b01, 2'b00, 2'b01, 32'h4, 32'h0, 32'h8, 32'h0);
      for (int i = 0; i < 5; i++) begin
         checkOutput("solo_p0_gnt", p0_gnt, 1);
         stepCycle();
      end
      applyStimulus(2'b11, 2'b00, 2'b01, 32'h4, 32'h0, 32'h8, 32'h0);
      checkOutput("sat_p1_gnt", p1_gnt, 1);
      checkOutput("sat_p0_gnt", p0_gnt, 0);
      stepCycle();
      checkOutput("unlock_p0_gnt", p0_gnt, 1);
      stepCycle();

      // Reset mid-read: pending rvalid dropped, then the first tie goes to p0.
      applyStimulus(2'b01, 2'b00, 2'b00, 32'h4, 32'h0, 32'h0, 32'h0);
      checkOutput("mid_p0_gnt", p0_gnt, 1);
      stepCycle();
      rst_n = 1'b0;
      applyStimulus(2'b11, 2'b01, 2'b00, 32'h0, 32'h5555_5555, 32'h8, 32'h0);
      checkOutput("mid_p0_rvalid", p0_rvalid, 0);
      checkOutput("mid_p0_rdata", p0_rdata, 0);
      checkOutput("mid_p0_gnt_rst", p0_gnt, 0);
      checkOutput("mid_mem_write", mem_write, 0);
      stepCycle();
      #2 rst_n = 1'b1;
      applyStimulus(2'b11, 2'b00, 2'b00, 32'h4, 32'h0, 32'h8, 32'h0);
      checkOutput("post_p0_gnt", p0_gnt, 1);
      checkOutput("post_p1_gnt", p1_gnt, 0);
      stepCycle();
      checkOutput("post_p0_rvalid", p0_rvalid, 1);
      checkOutput("post_p0_rdata", p0_rdata, 32'h1111_1111);
      checkOutput("post_p1_gnt2", p1_gnt, 1);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   // Safety net so the run always terminates.
   initial begin
      #20000;
      $display("[TB] FAIL timeout: observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
